sha256_stream_core: RTL
=======================

SHA256_STREAM_CORE -- requirements
Module: sha256_stream_core

Interface
REQ-001 SHALL have parameter NBLK_W, default 2, meaning the width of the block-count input; a job holds up to 2^NBLK_W-1 blocks.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  job request, sampled in IDLE only.
REQ-005 SHALL have port nblocks  input  NBLK_W  count of 512-bit blocks in the job, sampled with start; 0 is treated as 1.
REQ-006 SHALL have port dbl  input  1  double-hash request, sampled with start.
REQ-007 SHALL have port msg_valid  input  1  msg_in holds a valid word.
REQ-008 SHALL have port msg_in  input  32  message word, big-endian W0 first; the caller supplies padding.
REQ-009 SHALL have port msg_ready  output  1  core accepts msg_in this cycle.
REQ-010 SHALL have port busy  output  1  a job is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse: digest is valid.
REQ-012 SHALL have port digest  output  256  H0..H7 concatenated, H0 in [255:224].

Function
REQ-013 States SHALL be IDLE, LOAD, ROUND, UPDATE, PAD, DONE.
REQ-014 IDLE: start=1 latches nblocks and dbl, loads H0..H7 with the SHA-256 IV, sets busy, goes to LOAD.
REQ-015 LOAD: msg_ready=1; each msg_valid&&msg_ready cycle stores one word into W[0..15]; after the 16th word, go to ROUND.
REQ-016 msg_valid low in LOAD SHALL stall with no state change; msg_ready SHALL be 0 in every other state.
REQ-017 ROUND: one SHA-256 round per cycle, t=0..63; a..h start from current H; W[t] for t>=16 from a rolling 16-word schedule; K from internal 64-entry constant table.
REQ-018 UPDATE (1 cycle): H[i] <= H[i] + working register i, modulo 2^32; decrement remaining blocks.
REQ-019 After UPDATE: blocks remain -> LOAD; last block with dbl=1 and DOUBLE_HASH_EN -> PAD; otherwise -> DONE.
REQ-020 PAD (1 cycle): W0..W7 <= H0..H7, W8=32'h80000000, W9..W14=0, W15=32'h00000100; H <= IV; go to ROUND; on the following UPDATE go to DONE.
REQ-021 DONE (1 cycle): done=1, busy=0, go to IDLE; digest holds until the next start is accepted.
REQ-022 Latency, msg_valid held high: done SHALL assert 82*nblocks cycles after the start cycle, plus 66 if a second pass runs.
REQ-023 start while busy SHALL be ignored; start in the DONE cycle SHALL be ignored.
REQ-024 Extra msg_valid beats outside LOAD SHALL NOT be consumed.

Reset
REQ-025 rst=1 SHALL, asynchronously and at any state including mid-round, force IDLE with busy=0, done=0, msg_ready=0, digest=0, block counter and round counter =0.
REQ-026 A job interrupted by reset SHALL NOT produce done; the first start after release SHALL begin a fresh job.

Configuration
REQ-027 Macro SHA256_DOUBLE_HASH_EN defined: PAD state and second pass are compiled in and dbl=1 selects SHA256(SHA256(msg)).
REQ-028 Macro undefined: PAD logic is absent, dbl is ignored, and every job ends after its last UPDATE.

Verification
REQ-029 Scenario: nblocks=1, words 61626380, 14x0, 00000018, valid held high -> done at +82, digest ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
REQ-030 Scenario: nblocks=2, padded "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" -> done at +164, digest 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
REQ-031 Scenario: REQ-029 stimulus with dbl=1 and macro defined -> done at +148, digest 4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358; with macro undefined -> REQ-029 digest at +82.
REQ-032 Scenario: REQ-029 stimulus with msg_valid low on every other cycle -> 16 words accepted over 31 cycles, same digest, done at +97.
REQ-033 Scenario: rst pulsed during ROUND t=30 -> busy=0 and digest=0 immediately, no done; a new REQ-029 job then passes.
REQ-034 Scenario: start pulsed during LOAD and in the DONE cycle -> ignored; the original job's digest is unchanged.

Source files
------------

// File: rtl/sha256_stream_core.sv
// Streaming SHA-256 core: loads 16-word blocks, runs one round per cycle and chains blocks of a job.
// Optional macro SHA256_DOUBLE_HASH_EN compiles in the PAD state for SHA256(SHA256(msg)).
module sha256_stream_core #(
  parameter int NBLK_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NBLK_W-1:0] nblocks,
  input  logic              dbl,
  input  logic              msg_valid,
  input  logic [31:0]       msg_in,
  output logic              msg_ready,
  output logic              busy,
  output logic              done,
  output logic [255:0]      digest
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_ROUND  = 3'd2,
    S_UPDATE = 3'd3,
    S_PAD    = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t            r_state;
  logic [31:0]       r_h  [8];
  logic [31:0]       r_wk [8];
  logic [31:0]       r_w  [16];
  logic [5:0]        r_t;
  logic [3:0]        r_cnt;
  logic [NBLK_W-1:0] r_blk;
  logic              r_dbl;
  logic              r_second;
  logic              r_init;
  logic              r_msg_ready;
  logic              r_busy;
  logic              r_done;

  logic [31:0] w_t1;
  logic [31:0] w_t2;
  logic [31:0] w_wnew;

  // r_w[0] is always W[t]; r_w[15] receives W[t+16] as the window rolls.
  assign w_t1   = r_wk[7] + bsig1(r_wk[4]) + ((r_wk[4] & r_wk[5]) ^ (~r_wk[4] & r_wk[6]))
                + K_TAB[r_t] + r_w[0];
  assign w_t2   = bsig0(r_wk[0]) + ((r_wk[0] & r_wk[1]) ^ (r_wk[0] & r_wk[2]) ^ (r_wk[1] & r_wk[2]));
  assign w_wnew = ssig1(r_w[14]) + r_w[9] + ssig0(r_w[1]) + r_w[0];

  assign msg_ready = r_msg_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign digest    = {r_h[0], r_h[1], r_h[2], r_h[3], r_h[4], r_h[5], r_h[6], r_h[7]};

`ifndef SHA256_DOUBLE_HASH_EN
  logic w_unused_dbl;
  assign w_unused_dbl = dbl;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_t         <= 6'd0;
      r_cnt       <= 4'd0;
      r_blk       <= '0;
      r_dbl       <= 1'b0;
      r_second    <= 1'b0;
      r_init      <= 1'b0;
      r_msg_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_h[i]  <= 32'd0;
        r_wk[i] <= 32'd0;
      end
      for (int i = 0; i < 16; i++) r_w[i] <= 32'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_blk       <= (nblocks == '0) ? NBLK_W'(1) : nblocks;
`ifdef SHA256_DOUBLE_HASH_EN
            r_dbl       <= dbl;
`endif
            r_second    <= 1'b0;
            r_cnt       <= 4'd0;
            r_msg_ready <= 1'b1;
            r_busy      <= 1'b1;
            for (int i = 0; i < 8; i++) r_h[i] <= IV[i];
            r_state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (msg_valid && r_msg_ready) begin
            for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
            r_w[15] <= msg_in;
            r_cnt   <= r_cnt + 4'd1;
            if (r_cnt == 4'd15) begin
              r_msg_ready <= 1'b0;
              r_init      <= 1'b1;
              r_t         <= 6'd0;
              r_state     <= S_ROUND;
            end
          end
        end
        S_ROUND: begin
          // A message block spends one extra cycle copying H into a..h; PAD preloads them itself.
          if (r_init) begin
            for (int i = 0; i < 8; i++) r_wk[i] <= r_h[i];
            r_init <= 1'b0;
          end else begin
            r_wk[0] <= w_t1 + w_t2;
            r_wk[1] <= r_wk[0];
            r_wk[2] <= r_wk[1];
            r_wk[3] <= r_wk[2];
            r_wk[4] <= r_wk[3] + w_t1;
            r_wk[5] <= r_wk[4];
            r_wk[6] <= r_wk[5];
            r_wk[7] <= r_wk[6];
            for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
            r_w[15] <= w_wnew;
            r_t     <= r_t + 6'd1;
            if (r_t == 6'd63) r_state <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          for (int i = 0; i < 8; i++) r_h[i] <= r_h[i] + r_wk[i];
          if (!r_second && (r_blk != NBLK_W'(1))) begin
            r_blk       <= r_blk - NBLK_W'(1);
            r_cnt       <= 4'd0;
            r_msg_ready <= 1'b1;
            r_state     <= S_LOAD;
`ifdef SHA256_DOUBLE_HASH_EN
          end else if (!r_second && r_dbl) begin
            r_blk   <= '0;
            r_state <= S_PAD;
`endif
          end else begin
            r_blk   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
`ifdef SHA256_DOUBLE_HASH_EN
        S_PAD: begin
          for (int i = 0; i < 8; i++) begin
            r_w[i]  <= r_h[i];
            r_h[i]  <= IV[i];
            r_wk[i] <= IV[i];
          end
          r_w[8]   <= 32'h80000000;
          for (int i = 9; i < 15; i++) r_w[i] <= 32'd0;
          r_w[15]  <= 32'h00000100;
          r_second <= 1'b1;
          r_init   <= 1'b0;
          r_t      <= 6'd0;
          r_state  <= S_ROUND;
        end
`endif
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
